// File: rtl/sram_master.sv
// Single-port SRAM master: byte/half/word loads and stores with lane steering and a valid/ready response.
// Optional misalignment error reporting is enabled by defining SRAM_MASTER_ALIGN_CHECK_EN.
module sram_master #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  // state | meaning
  // IDLE  | no transaction outstanding, ready for a request
  // RD    | load issued last cycle, SRAM data arrives this cycle
  // RESP  | response presented, waiting for resp_ready
  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        err;
  logic        is_byte, is_half;
  logic [1:0]  lane_addr;
  logic [1:0]  addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign is_byte = (req_size == 2'b00);
  assign is_half = (req_size == 2'b01);

`ifdef SRAM_MASTER_ALIGN_CHECK_EN
  assign err = (is_half && req_addr[0]) ||
               (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
`else
  assign err = 1'b0;
`endif

  // Misaligned low bits are forced to the natural alignment of the access size.
  assign lane_addr = is_byte ? req_addr[1:0] :
                     is_half ? {req_addr[1], 1'b0} : 2'b00;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (!req_we && !err) ? RD : RESP;
      RD:   state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          if (accept) state_nxt = (!req_we && !err) ? RD : RESP;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) || ((state == RESP) && resp_ready);
    sram_en    = req_valid && req_ready && !err && !rst;
    sram_addr  = req_addr[ADDR_WIDTH+1:2];
    sram_wdata = is_byte ? {4{req_wdata[7:0]}} :
                 is_half ? {2{req_wdata[15:0]}} : req_wdata;
    sram_we    = 4'b0000;
    if (sram_en && req_we) begin
      if (is_byte)      sram_we = 4'b0001 << lane_addr;
      else if (is_half) sram_we = 4'b0011 << lane_addr;
      else              sram_we = 4'b1111;
    end
  end

  always_comb begin
    case (addr_q)
      2'd0:    ld_byte = sram_rdata[7:0];
      2'd1:    ld_byte = sram_rdata[15:8];
      2'd2:    ld_byte = sram_rdata[23:16];
      default: ld_byte = sram_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: load_data = sram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= 2'b00;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept && !req_we && !err) begin
        addr_q   <= lane_addr;
        size_q   <= req_size;
        signed_q <= req_signed;
      end
      if (accept) begin
        // Stores and errors respond next cycle; loads wait for RD to fill in data.
        resp_valid <= req_we || err;
        resp_rdata <= 32'h0;
        resp_err   <= err;
      end else if (state == RD) begin
        resp_valid <= 1'b1;
        resp_rdata <= load_data;
        resp_err   <= 1'b0;
      end else if ((state == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= 32'h0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule
